// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-boundary loading and leading-zero blanking.
// Optional digit blinking is enabled by defining SCAN_BLINK_EN.
`default_nettype none

module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*5-1:0] frame_in,
    input  logic                    load,
    output logic                    load_ready,
    input  logic                    lz_en,
`ifdef SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4:0]              code,
    output logic                    frame_tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [4:0]    BLANK   = 5'b11111;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 4 || BLINK_DIV < 1) begin : g_bad_param
        $error("seg_scan_ctrl: parameter out of range");
    end

    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [4:0]                    code_q, code_d;
    logic                          ft_q, ft_d;
    logic                          pend_q, pend_d;
    logic [NUM_DIGITS-1:0][4:0]    stage_q, stage_d;
    logic [NUM_DIGITS-1:0][4:0]    shadow_q, shadow_d;

    logic                          tick, wrap;
    logic [NUM_DIGITS-1:0]         lz_blank;
    logic                          lz_run;
    logic [4:0]                    disp;

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    // Zeros are blanked from the most significant digit down until the first
    // non-zero code; a dp-bearing zero is non-zero here, and digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && shadow_q[i] == 5'b00000) lz_blank[i] = 1'b1;
            else                                   lz_run      = 1'b0;
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        disp = shadow_q[idx_q];
        if (lz_en && lz_blank[idx_q]) disp = BLANK;
`ifdef SCAN_BLINK_EN
        // Blink overrides after blanking; the anode keeps strobing.
        if (phase_q && blink_mask[idx_q]) disp = BLANK;
`endif
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        an_d     = ~(NUM_DIGITS'(1) << idx_q);
        code_d   = disp;
        ft_d     = wrap;
        stage_d  = stage_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;

        // The tick cycle opens a one-clock all-off gap; the new digit and its
        // code appear together on the following edge.
        if (tick) begin
            idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            an_d   = '1;
            code_d = code_q;
        end

        if (load && !pend_q) begin
            stage_d = frame_in;
            pend_d  = 1'b1;
        end

        if (wrap && pend_q) begin
            shadow_d = stage_q;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            code_q   <= BLANK;
            ft_q     <= 1'b0;
            pend_q   <= 1'b0;
            stage_q  <= {NUM_DIGITS{BLANK}};
            shadow_q <= {NUM_DIGITS{BLANK}};
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            code_q   <= code_d;
            ft_q     <= ft_d;
            pend_q   <= pend_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
        end
    end

    assign load_ready = ~pend_q;
    assign an         = an_q;
    assign code       = code_q;
    assign frame_tick = ft_q;

endmodule

`default_nettype wire
